// File: rtl/mem_access.sv
// Memory-stage unit: issues one load/store at a time on a single-outstanding data bus,
// aligns byte lanes, extends load data and emits one writeback record per accepted op.

package mem_access_pkg;

  typedef enum logic [2:0] {
    MemWord  = 3'd0,
    MemHalf  = 3'd1,
    MemHalfU = 3'd2,
    MemByte  = 3'd3,
    MemByteU = 3'd4
  } mem_type_e;

  typedef struct packed {
    logic        mem_read_ena;
    logic        mem_write_ena;
    logic        write_reg_need;
    logic [4:0]  write_reg_addr;
    logic [31:0] result;
    logic [31:0] write_data;
    mem_type_e   mem_type;
    logic [31:0] addr;
  } mem_require_t;

endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  mem_require_t mem_require,
  input  logic         flush,
  output logic         d_req,
  output logic         d_we,
  output logic [31:0]  d_addr,
  output logic [3:0]   d_wstrb,
  output logic [31:0]  d_wdata,
  input  logic         d_gnt,
  input  logic         d_rvalid,
  input  logic [31:0]  d_rdata,
  output logic         wb_valid,
  output logic         wb_reg_need,
  output logic [4:0]   wb_reg_addr,
  output logic [31:0]  wb_data,
  output logic         addr_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic        op_we_q;
  mem_type_e   op_type_q;
  logic [1:0]  op_lane_q;
  logic        op_need_q;
  logic [4:0]  op_rd_q;
  logic        discard_q;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign in_ready = (state_q == StIdle) && rst_n;
  // A flush in IDLE swallows whatever is presented that cycle.
  assign accept   = in_valid && in_ready && !flush;
  assign is_mem   = mem_require.mem_read_ena || mem_require.mem_write_ena;

  always_comb begin
    misaligned = 1'b0;
    case (mem_require.mem_type)
      MemWord:           misaligned = (mem_require.addr[1:0] != 2'b00);
      MemHalf, MemHalfU: misaligned = mem_require.addr[0];
      default:           misaligned = 1'b0;
    endcase
  end

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = mem_require.write_data;
    case (mem_require.mem_type)
      MemByte, MemByteU: begin
        st_strb  = 4'b0001 << mem_require.addr[1:0];
        st_wdata = {4{mem_require.write_data[7:0]}};
      end
      MemHalf, MemHalfU: begin
        st_strb  = mem_require.addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_require.write_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = mem_require.write_data;
      end
    endcase
  end

  assign ld_byte = d_rdata[8*op_lane_q +: 8];
  assign ld_half = d_rdata[16*op_lane_q[1] +: 16];

  always_comb begin
    ld_data = d_rdata;
    case (op_type_q)
      MemByte:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MemByteU: ld_data = {24'h0, ld_byte};
      MemHalf:  ld_data = {{16{ld_half[15]}}, ld_half};
      MemHalfU: ld_data = {16'h0, ld_half};
      default:  ld_data = d_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_we_q     <= 1'b0;
      op_type_q   <= MemWord;
      op_lane_q   <= 2'b00;
      op_need_q   <= 1'b0;
      op_rd_q     <= 5'd0;
      discard_q   <= 1'b0;
      d_req       <= 1'b0;
      d_we        <= 1'b0;
      d_addr      <= 32'h0;
      d_wstrb     <= 4'h0;
      d_wdata     <= 32'h0;
      wb_valid    <= 1'b0;
      wb_reg_need <= 1'b0;
      wb_reg_addr <= 5'd0;
      wb_data     <= 32'h0;
      addr_err    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid    <= 1'b1;
              wb_reg_need <= mem_require.write_reg_need;
              wb_reg_addr <= mem_require.write_reg_addr;
              wb_data     <= mem_require.result;
              addr_err    <= 1'b0;
            end else if (misaligned) begin
              wb_valid    <= 1'b1;
              wb_reg_need <= 1'b0;
              wb_reg_addr <= mem_require.write_reg_addr;
              wb_data     <= mem_require.result;
              addr_err    <= 1'b1;
            end else begin
              state_q   <= StReq;
              op_we_q   <= mem_require.mem_write_ena;
              op_type_q <= mem_require.mem_type;
              op_lane_q <= mem_require.addr[1:0];
              op_need_q <= mem_require.write_reg_need;
              op_rd_q   <= mem_require.write_reg_addr;
              discard_q <= 1'b0;
              d_req     <= 1'b1;
              d_we      <= mem_require.mem_write_ena;
              d_addr    <= {mem_require.addr[31:2], 2'b00};
              d_wstrb   <= mem_require.mem_write_ena ? st_strb : 4'h0;
              d_wdata   <= st_wdata;
            end
          end
        end
        StReq: begin
          if (d_gnt) begin
            // The bus has committed the transfer; a flush can only hide its result.
            d_req <= 1'b0;
            if (op_we_q) begin
              state_q <= StIdle;
              if (!flush) begin
                wb_valid    <= 1'b1;
                wb_reg_need <= 1'b0;
                wb_reg_addr <= op_rd_q;
                wb_data     <= 32'h0;
                addr_err    <= 1'b0;
              end
            end else begin
              state_q   <= StWait;
              discard_q <= flush;
            end
          end else if (flush) begin
            d_req   <= 1'b0;
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (d_rvalid) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
            if (!flush && !discard_q) begin
              wb_valid    <= 1'b1;
              wb_reg_need <= op_need_q;
              wb_reg_addr <= op_rd_q;
              wb_data     <= ld_data;
              addr_err    <= 1'b0;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: drives ops and a bus responder, compares against a
// transaction-level reference of the alignment, lane and extension rules.

module tb_mem_access;
  import mem_access_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  mem_require_t mem_require;
  logic         flush;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [3:0]   d_wstrb;
  logic [31:0]  d_wdata;
  logic         d_gnt;
  logic         d_rvalid;
  logic [31:0]  d_rdata;
  logic         wb_valid;
  logic         wb_reg_need;
  logic [4:0]   wb_reg_addr;
  logic [31:0]  wb_data;
  logic         addr_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_access dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_require (mem_require),
    .flush       (flush),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wstrb     (d_wstrb),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .wb_valid    (wb_valid),
    .wb_reg_need (wb_reg_need),
    .wb_reg_addr (wb_reg_addr),
    .wb_data     (wb_data),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit misaligned_ref(input mem_type_e t, input logic [31:0] a);
    if (t == MemWord) return (a % 4) != 0;
    if (t == MemHalf || t == MemHalfU) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] strb_ref(input mem_type_e t, input logic [31:0] a);
    if (t == MemByte || t == MemByteU) return 32'd1 << (a % 4);
    if (t == MemHalf || t == MemHalfU) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] wdata_ref(input mem_type_e t, input logic [31:0] wd);
    if (t == MemByte || t == MemByteU) return (wd & 32'hFF) * 32'h0101_0101;
    if (t == MemHalf || t == MemHalfU) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] load_ref(input mem_type_e t, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    if (t == MemByte || t == MemByteU) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (t == MemByte && v > 127) v = v - 256;
    end else if (t == MemHalf || t == MemHalfU) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (t == MemHalf && v > 32767) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic mem_require_t make_req(input logic rd_en, input logic wr_en,
      input logic need, input logic [4:0] rd, input logic [31:0] res, input logic [31:0] wd,
      input mem_type_e t, input logic [31:0] a);
    mem_require_t r;
    r.mem_read_ena   = rd_en;
    r.mem_write_ena  = wr_en;
    r.write_reg_need = need;
    r.write_reg_addr = rd;
    r.result         = res;
    r.write_data     = wd;
    r.mem_type       = t;
    r.addr           = a;
    return r;
  endfunction

  // Present one op, act as the bus with the given grant/response delays, check everything.
  task automatic run_op(input mem_require_t r, input int gd, input int rvd,
                        input logic [31:0] rdata);
    bit is_store, is_load, misal;
    logic [31:0] exp_strb;
    is_store = r.mem_write_ena;
    is_load  = r.mem_read_ena && !r.mem_write_ena;
    misal    = (is_store || is_load) && misaligned_ref(r.mem_type, r.addr);
    exp_strb = is_store ? strb_ref(r.mem_type, r.addr) : 32'd0;
    check_eq("ready_before", 32'(in_ready), 1);
    in_valid    = 1'b1;
    mem_require = r;
    @(negedge clk);
    in_valid               = 1'b0;
    mem_require.addr       = $urandom();
    mem_require.write_data = $urandom();
    if ((!is_store && !is_load) || misal) begin
      check_eq("pass_wb_valid", 32'(wb_valid), 1);
      check_eq("pass_no_req", 32'(d_req), 0);
      check_eq("pass_need", 32'(wb_reg_need), misal ? 32'd0 : 32'(r.write_reg_need));
      check_eq("pass_rd", 32'(wb_reg_addr), 32'(r.write_reg_addr));
      check_eq("pass_err", 32'(addr_err), 32'(misal));
      if (!misal) check_eq("pass_data", wb_data, r.result);
      check_eq("pass_ready", 32'(in_ready), 1);
    end else begin
      check_eq("req_ready", 32'(in_ready), 0);
      for (int g = 0; g <= gd; g++) begin
        d_gnt = (g == gd);
        check_eq("req_d_req", 32'(d_req), 1);
        check_eq("req_we", 32'(d_we), 32'(is_store));
        check_eq("req_addr", d_addr, r.addr & 32'hFFFF_FFFC);
        check_eq("req_strb", 32'(d_wstrb), exp_strb);
        if (is_store) check_eq("req_wdata", d_wdata, wdata_ref(r.mem_type, r.write_data));
        check_eq("req_no_wb", 32'(wb_valid), 0);
        @(negedge clk);
      end
      d_gnt = 1'b0;
      check_eq("gnt_req_drop", 32'(d_req), 0);
      if (is_store) begin
        check_eq("st_wb_valid", 32'(wb_valid), 1);
        check_eq("st_need", 32'(wb_reg_need), 0);
        check_eq("st_err", 32'(addr_err), 0);
        check_eq("st_ready", 32'(in_ready), 1);
      end else begin
        for (int k = 0; k <= rvd; k++) begin
          d_rvalid = (k == rvd);
          d_rdata  = (k == rvd) ? rdata : $urandom();
          check_eq("wait_no_wb", 32'(wb_valid), 0);
          check_eq("wait_ready", 32'(in_ready), 0);
          @(negedge clk);
        end
        d_rvalid = 1'b0;
        check_eq("ld_wb_valid", 32'(wb_valid), 1);
        check_eq("ld_data", wb_data, load_ref(r.mem_type, r.addr, rdata));
        check_eq("ld_need", 32'(wb_reg_need), 32'(r.write_reg_need));
        check_eq("ld_rd", 32'(wb_reg_addr), 32'(r.write_reg_addr));
        check_eq("ld_err", 32'(addr_err), 0);
        check_eq("ld_ready", 32'(in_ready), 1);
      end
    end
    @(negedge clk);
    check_eq("wb_pulse", 32'(wb_valid), 0);
  endtask

  initial begin
    mem_require_t r;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    flush       = 1'b0;
    d_gnt       = 1'b0;
    d_rvalid    = 1'b0;
    d_rdata     = 32'h0;
    mem_require = make_req(0, 0, 0, 5'd0, 32'h0, 32'h0, MemWord, 32'h0);
    #12;
    check_eq("rst_ready", 32'(in_ready), 0);
    check_eq("rst_outs", {d_req, d_we, wb_valid, wb_reg_need, addr_err, d_wstrb, wb_reg_addr}, 0);
    check_eq("rst_bus", d_addr | d_wdata | wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU pass-through
    run_op(make_req(0, 0, 1, 5'd5, 32'h1234_5678, 32'h0, MemWord, 32'h0), 0, 0, 32'h0);
    // Signed / unsigned byte loads
    run_op(make_req(1, 0, 1, 5'd7, 32'h0, 32'h0, MemByte, 32'h1003), 0, 0, 32'h80FF_0000);
    run_op(make_req(1, 0, 1, 5'd7, 32'h0, 32'h0, MemByteU, 32'h1003), 0, 0, 32'h80FF_0000);
    // Half store with delayed grant
    run_op(make_req(0, 1, 0, 5'd0, 32'h0, 32'hAAAA_BEEF, MemHalf, 32'h2002), 3, 0, 32'h0);
    // Misaligned word load
    run_op(make_req(1, 0, 1, 5'd9, 32'h0, 32'h0, MemWord, 32'h3002), 0, 0, 32'h0);

    // Back-to-back pass-through ops
    in_valid    = 1'b1;
    mem_require = make_req(0, 0, 1, 5'd1, 32'hCAFE_0001, 32'h0, MemWord, 32'h0);
    @(negedge clk);
    check_eq("b2b_first", wb_data, 32'hCAFE_0001);
    check_eq("b2b_ready", 32'(in_ready), 1);
    mem_require = make_req(0, 0, 1, 5'd2, 32'hCAFE_0002, 32'h0, MemWord, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("b2b_second", {wb_valid, wb_data[30:0]}, {1'b1, 31'h4AFE_0002});
    @(negedge clk);

    // Flush in IDLE ignores the presented op
    in_valid    = 1'b1;
    flush       = 1'b1;
    mem_require = make_req(1, 0, 1, 5'd3, 32'h0, 32'h0, MemWord, 32'h40);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_eq("fl_idle", {30'h0, wb_valid, d_req}, 0);

    // Flush in REQ without grant drops the store
    in_valid    = 1'b1;
    mem_require = make_req(0, 1, 0, 5'd0, 32'h0, 32'h1111_2222, MemWord, 32'h80);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("fl_req_drop", {30'h0, d_req, wb_valid}, 0);
    check_eq("fl_req_ready", 32'(in_ready), 1);
    @(negedge clk);
    check_eq("fl_req_quiet", 32'(wb_valid), 0);

    // Flush with grant: store completes silently
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    d_gnt    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    d_gnt = 1'b0;
    check_eq("fl_gnt_st", {30'h0, d_req, wb_valid}, 0);
    check_eq("fl_gnt_st_rdy", 32'(in_ready), 1);

    // Flush with grant: load waits for data and discards it
    in_valid    = 1'b1;
    mem_require = make_req(1, 0, 1, 5'd4, 32'h0, 32'h0, MemByte, 32'h91);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    d_gnt    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    d_gnt    = 1'b0;
    check_eq("fl_gnt_ld_wait", 32'(in_ready), 0);
    d_rvalid = 1'b1;
    @(negedge clk);
    d_rvalid = 1'b0;
    check_eq("fl_gnt_ld_drop", 32'(wb_valid), 0);
    check_eq("fl_gnt_ld_rdy", 32'(in_ready), 1);

    // Flush in WAIT, data two cycles later
    in_valid    = 1'b1;
    mem_require = make_req(1, 0, 1, 5'd6, 32'h0, 32'h0, MemWord, 32'h100);
    @(negedge clk);
    in_valid = 1'b0;
    d_gnt    = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("fl_wait_hold", 32'(in_ready), 0);
    @(negedge clk);
    d_rvalid = 1'b1;
    d_rdata  = 32'h5555_AAAA;
    check_eq("fl_wait_hold2", 32'(in_ready), 0);
    @(negedge clk);
    d_rvalid = 1'b0;
    check_eq("fl_wait_drop", 32'(wb_valid), 0);
    check_eq("fl_wait_rdy", 32'(in_ready), 1);
    @(negedge clk);
    check_eq("fl_wait_quiet", 32'(wb_valid), 0);

    // Reset mid-request
    in_valid    = 1'b1;
    mem_require = make_req(1, 0, 1, 5'd8, 32'h0, 32'h0, MemWord, 32'h2000);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rr_req_up", 32'(d_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rr_req_drop", 32'(d_req), 0);
    check_eq("rr_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rr_ready", 32'(in_ready), 1);
    check_eq("rr_quiet", {30'h0, wb_valid, d_req}, 0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      r.mem_read_ena   = 1'($urandom_range(0, 1));
      r.mem_write_ena  = 1'($urandom_range(0, 1));
      r.write_reg_need = 1'($urandom_range(0, 1));
      r.write_reg_addr = 5'($urandom_range(0, 31));
      r.result         = $urandom();
      r.write_data     = $urandom();
      r.mem_type       = mem_type_e'(3'($urandom_range(0, 4)));
      r.addr           = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (r.mem_type == MemWord) r.addr = r.addr & 32'hFFFF_FFFC;
        if (r.mem_type == MemHalf || r.mem_type == MemHalfU) r.addr = r.addr & 32'hFFFF_FFFE;
      end
      run_op(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
